pipe_stage_latch: RTL and testbench

Parametrised elastic pipeline latch and successor to the fixed-field enable/flush stage latches. It carries an opaque WIDTH-bit payload between pipeline stages using a valid/ready handshake instead of a bare enable. It includes an optional two-entry skid buffer, so upstream ready is fully registered. Synchronous flush inserts a bubble, and every empty slot presents a configurable NOP payload.

---
 rtl/pipe_stage_latch_pkg.sv | 19 +
 rtl/pipe_stage_latch_sat_counter.sv | 38 +++
 rtl/pipe_stage_latch.sv | 138 +++++++++++++
 tb/tb_pipe_stage_latch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_latch_pkg.sv
// +------------------------------------------------------------------+
// | pipe_stage_pkg : shared types and constants for pipe_stage_latch |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_stage_pkg;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_FULL  = 2'd1,
    STG_SKID  = 2'd2
  } stage_state_t;

  localparam int STALL_CNT_W = 32;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_latch_sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter : enable-driven up counter that sticks at all-ones   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_latch.sv
// +------------------------------------------------------------------+
// | pipe_stage_latch : elastic valid/ready stage with optional skid  |
// | buffer and flush; stall statistics under PIPE_STAGE_STATS_EN.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_stage_latch
  import pipe_stage_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = (state_q != STG_EMPTY);
  // main_q is reloaded with NOP_VALUE whenever it empties, so no output mux
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      STG_FULL: occupancy = 2'd1;
      STG_SKID: occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  generate
    if (SKID) begin : g_skid
      assign in_ready = (state_q != STG_SKID);

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          skid_q <= NOP_VALUE;
        end else begin
          skid_q <= skid_d;
        end
      end
    end else begin : g_single
      logic unused_skid;
      assign in_ready    = (state_q == STG_EMPTY) || out_ready;
      assign skid_q      = NOP_VALUE;
      assign unused_skid = ^skid_d;
    end
  endgenerate

  // Without a skid entry, in_ready in FULL equals out_ready, so the
  // FULL->SKID branch below is unreachable in the single-register build.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = STG_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        STG_EMPTY: begin
          if (in_fire) begin
            state_d = STG_FULL;
            main_d  = in_data;
          end
        end
        STG_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = STG_SKID;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = STG_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        STG_SKID: begin
          if (out_fire) begin
            state_d = STG_FULL;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = STG_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= STG_EMPTY;
      main_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .en_i    (out_valid && !out_ready),
    .count_o (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
// Directed testbench for pipe_stage_latch: SKID=1 (NOP 0xDEAD) and SKID=0 instances.
`default_nettype none

module tb_pipe_stage_latch;

  logic        CLK;
  logic        nRST;
  int          total;
  int          bad;

  // SKID=1 instance
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data, stall_cnt;
  logic [1:0]  occupancy;

  // SKID=0 instance
  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0]  in_data0, out_data0;
  logic [31:0] stall_cnt0;
  logic [1:0]  occupancy0;

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [31:0] EXP_STALL5 = 32'd5;
`else
  localparam logic [31:0] EXP_STALL5 = 32'd0;
`endif

  pipe_stage_latch #(.WIDTH(32), .NOP_VALUE(32'hDEAD), .SKID(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_latch #(.WIDTH(8), .NOP_VALUE(8'h00), .SKID(1'b0)) dut0 (
    .CLK(CLK), .nRST(nRST), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
    flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'hDEAD) begin bad++; $display("FAIL rst_out_data got=%h exp=0000dead", out_data); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    total++; if (out_valid0 !== 1'b0 || out_data0 !== 8'h00) begin bad++; $display("FAIL rst_skid0_out got=%b/%h exp=0/00", out_valid0, out_data0); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_pass_through();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin bad++; $display("FAIL pass_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
      total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL pass_occ_rdy[%0d] got=%0d/%b exp=1/1", i, occupancy, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD || occupancy !== 2'd0) begin bad++; $display("FAIL pass_drain got=%b/%h/%0d exp=0/0000dead/0", out_valid, out_data, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA1;
    tick();
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hA1) begin bad++; $display("FAIL bp_first got=%0d/%b/%h exp=1/1/a1", occupancy, in_ready, out_data); end
    in_data = 32'hA2;
    tick();
    total++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d/%b exp=2/0", occupancy, in_ready); end
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin bad++; $display("FAIL bp_head got=%b/%h exp=1/a1", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    total++; if (out_data !== 32'hA1 || occupancy !== 2'd2) begin bad++; $display("FAIL bp_hold got=%h/%0d exp=a1/2", out_data, occupancy); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 32'hA2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%0d/%b exp=a2/1/1", out_data, occupancy, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD || occupancy !== 2'd0) begin bad++; $display("FAIL bp_empty got=%b/%h/%0d exp=0/0000dead/0", out_valid, out_data, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h01;
    tick();
    in_data = 32'h02;
    tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL fl_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = 32'hFF;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD || occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL fl_skid got=%b/%h/%0d/%b exp=0/0000dead/0/1", out_valid, out_data, occupancy, in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD) begin bad++; $display("FAIL fl_skid_after got=%b/%h exp=0/0000dead", out_valid, out_data); end
    // flush while FULL and accepting: the incoming word must be dropped
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h05;
    tick();
    total++; if (out_data !== 32'h05) begin bad++; $display("FAIL fl_full_pre got=%h exp=05", out_data); end
    flush = 1'b1; in_data = 32'hFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD || occupancy !== 2'd0) begin bad++; $display("FAIL fl_full got=%b/%h/%0d exp=0/0000dead/0", out_valid, out_data, occupancy); end
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD) begin bad++; $display("FAIL fl_full_after got=%b/%h exp=0/0000dead", out_valid, out_data); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h31;
    tick();
    in_data = 32'h32;
    tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rm_pre_occ got=%0d exp=2", occupancy); end
    #2 nRST = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD || occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rm_async got=%b/%h/%0d/%b exp=0/0000dead/0/1", out_valid, out_data, occupancy, in_ready); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rm_stall got=%0d exp=0", stall_cnt); end
    @(negedge CLK);
    nRST = 1'b1;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD || occupancy !== 2'd0) begin bad++; $display("FAIL rm_release got=%b/%h/%0d exp=0/0000dead/0", out_valid, out_data, occupancy); end
  endtask

  task automatic test_stats();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h41;
    tick();
    in_valid = 1'b0;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL st_start got=%0d exp=0", stall_cnt); end
    repeat (5) tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h41) begin bad++; $display("FAIL st_hold got=%b/%h exp=1/41", out_valid, out_data); end
    total++; if (stall_cnt !== EXP_STALL5) begin bad++; $display("FAIL st_count got=%0d exp=%0d", stall_cnt, EXP_STALL5); end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (stall_cnt !== EXP_STALL5 || out_valid !== 1'b0) begin bad++; $display("FAIL st_flush got=%0d/%b exp=%0d/0", stall_cnt, out_valid, EXP_STALL5); end
    tick();
    total++; if (stall_cnt !== EXP_STALL5) begin bad++; $display("FAIL st_after got=%0d exp=%0d", stall_cnt, EXP_STALL5); end
  endtask

  task automatic test_skid0();
    logic [7:0] vals [2];
    vals[0] = 8'h20; vals[1] = 8'h30;
    out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 8'h10;
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_empty_rdy got=%b exp=1", in_ready0); end
    tick();
    total++; if (out_valid0 !== 1'b1 || out_data0 !== 8'h10 || occupancy0 !== 2'd1) begin bad++; $display("FAIL s0_load got=%b/%h/%0d exp=1/10/1", out_valid0, out_data0, occupancy0); end
    total++; if (in_ready0 !== 1'b0) begin bad++; $display("FAIL s0_full_rdy got=%b exp=0", in_ready0); end
    out_ready0 = 1'b1;
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL s0_comb_rdy got=%b exp=1", in_ready0); end
    for (int i = 0; i < 2; i++) begin
      in_data0 = vals[i];
      tick();
      total++; if (out_valid0 !== 1'b1 || out_data0 !== vals[i] || occupancy0 !== 2'd1) begin bad++; $display("FAIL s0_b2b[%0d] got=%b/%h/%0d exp=1/%h/1", i, out_valid0, out_data0, occupancy0, vals[i]); end
    end
    in_valid0 = 1'b0;
    tick();
    total++; if (out_valid0 !== 1'b0 || out_data0 !== 8'h00 || occupancy0 !== 2'd0) begin bad++; $display("FAIL s0_drain got=%b/%h/%0d exp=0/00/0", out_valid0, out_data0, occupancy0); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_stats();
    test_skid0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
